// File: rtl/sat_pkg.sv
// ----------------------------------------------------------------------------
// sat_pkg
// Shared types for the SAT solver BCP datapath (implication arbiter, conflict
// detector, imply stack).
//   MAX_VAR_COUNT : number of solver variables
//   VAR_W         : variable index width derived from MAX_VAR_COUNT
//   implication_t : one implication {var_idx, val}
//   bcp_state_t   : BCP round sequencing states
// ----------------------------------------------------------------------------
package sat_pkg;

   localparam int MAX_VAR_COUNT = 512;
   localparam int VAR_W         = $clog2(MAX_VAR_COUNT);

   typedef struct packed {
      logic [VAR_W-1:0] var_idx;
      logic             val;
   } implication_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } bcp_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request found when
// searching from ptr upward with wrap-around.
//   req       : request vector, one bit per requester
//   ptr       : highest-priority requester index for this cycle (0..N-1)
//   grant     : one-hot grant
//   grant_idx : binary index of the granted requester
//   any_grant : at least one request was granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             any_grant
);

   always_comb begin
      // NOTE: every output gets a default before the search loop so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      for (int k = 0; k < N; k++) begin
         int lane;
         lane = int'(ptr) + k;
         if (lane >= N) lane = lane - N;
         if (!any_grant && req[lane]) begin
            any_grant   = 1'b1;
            grant[lane] = 1'b1;
            grant_idx   = PTR_W'(lane);
         end
      end
   end

endmodule

// File: rtl/implication_arbiter.sv
// ----------------------------------------------------------------------------
// implication_arbiter
// Sequences one BCP round: grants at most one evaluator implication per cycle
// in round-robin order, forwards it to the conflict detector with zero-cycle
// latency, and reports round completion / conflict / implication count.
//   clock, reset        : clock, asynchronous active-low reset
//   start, abort, ack   : solver control pulses
//   evals_done          : evaluators have finished issuing for this round
//   req_valid/var_idx/val, req_ready : per-evaluator valid/ready channel
//   det_en/var_idx/val, det_conflict : presented implication and its verdict
//   bcp_done, bcp_conflict, conflict_var_idx, imply_count, busy : status
// ----------------------------------------------------------------------------
module implication_arbiter #(
   parameter int N_EVAL = 4,
   parameter int VAR_W  = sat_pkg::VAR_W,
   parameter int CNT_W  = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    ack,
   input  logic                    evals_done,
   input  logic [N_EVAL-1:0]       req_valid,
   input  logic [N_EVAL*VAR_W-1:0] req_var_idx,
   input  logic [N_EVAL-1:0]       req_val,
   output logic [N_EVAL-1:0]       req_ready,
   output logic                    det_en,
   output logic [VAR_W-1:0]        det_var_idx,
   output logic                    det_val,
   input  logic                    det_conflict,
   output logic                    bcp_done,
   output logic                    bcp_conflict,
   output logic [VAR_W-1:0]        conflict_var_idx,
   output logic [CNT_W-1:0]        imply_count,
   output logic                    busy
);

   import sat_pkg::*;

   localparam int PTR_W = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;

   bcp_state_t         state;
   logic [PTR_W-1:0]   rr_ptr;
   logic [N_EVAL-1:0]  grant;
   logic [PTR_W-1:0]   grant_idx;
   logic               any_grant;
   logic               xfer;

   rr_arbiter #(
      .N     (N_EVAL),
      .PTR_W (PTR_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // A grant is only real in RUN and never in an abort cycle; since the grant
   // is derived from req_valid, a grant is also a completed transfer.
   assign xfer = (state == RUN) && any_grant && !abort;

   assign req_ready   = xfer ? grant : '0;
   assign det_en      = xfer;
   assign det_var_idx = xfer ? req_var_idx[grant_idx * VAR_W +: VAR_W] : '0;
   assign det_val     = xfer ? req_val[grant_idx] : 1'b0;
   assign bcp_done    = (state == DONE);
   assign busy        = (state != IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         imply_count      <= '0;
         conflict_var_idx <= '0;
         bcp_conflict     <= 1'b0;
      end else if (abort) begin
         state        <= IDLE;
         bcp_conflict <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state        <= RUN;
                  imply_count  <= '0;
                  bcp_conflict <= 1'b0;
               end
            end
            RUN: begin
               if (xfer) begin
                  rr_ptr <= (grant_idx == PTR_W'(N_EVAL - 1)) ? '0
                                                              : grant_idx + PTR_W'(1);
                  if (det_conflict) begin
                     conflict_var_idx <= det_var_idx;
                     bcp_conflict     <= 1'b1;
                     state            <= DONE;
                  end else if (imply_count != '1) begin
                     imply_count <= imply_count + CNT_W'(1);
                  end
               end else if (evals_done) begin
                  // Pending requests always drain first: evals_done only
                  // closes the round on a cycle with nothing to grant.
                  state <= DONE;
               end
            end
            DONE: begin
               if (ack) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_implication_arbiter.sv
// ----------------------------------------------------------------------------
// tb_implication_arbiter
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a behavioural model of the BCP round, with literal
// expectations pinning the key scenarios.
// ----------------------------------------------------------------------------
module tb_implication_arbiter;

   localparam int N       = 4;
   localparam int VW      = 9;
   localparam int CW      = 10;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start, abort, ack, evals_done;
   logic [N-1:0]    req_valid;
   logic [N*VW-1:0] req_var_idx;
   logic [N-1:0]    req_val;
   logic [N-1:0]    req_ready;
   logic            det_en;
   logic [VW-1:0]   det_var_idx;
   logic            det_val;
   logic            det_conflict;
   logic            bcp_done;
   logic            bcp_conflict;
   logic [VW-1:0]   conflict_var_idx;
   logic [CW-1:0]   imply_count;
   logic            busy;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the round: in a round, finished with a result, or
   // neither (idle).
   bit m_active, m_finished, m_conf;
   int m_ptr, m_count, m_cvar;

   implication_arbiter #(.N_EVAL(N), .VAR_W(VW), .CNT_W(CW)) dut (
      .clock            (clk),
      .reset            (rst_n),
      .start            (start),
      .abort            (abort),
      .ack              (ack),
      .evals_done       (evals_done),
      .req_valid        (req_valid),
      .req_var_idx      (req_var_idx),
      .req_val          (req_val),
      .req_ready        (req_ready),
      .det_en           (det_en),
      .det_var_idx      (det_var_idx),
      .det_val          (det_val),
      .det_conflict     (det_conflict),
      .bcp_done         (bcp_done),
      .bcp_conflict     (bcp_conflict),
      .conflict_var_idx (conflict_var_idx),
      .imply_count      (imply_count),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lane_var(input int i);
      return int'(req_var_idx[i*VW +: VW]);
   endfunction

   task automatic set_lane(input int i, input int v, input bit b);
      req_var_idx[i*VW +: VW] = VW'(v);
      req_val[i]              = b;
   endtask

   task automatic clear_inputs();
      start = 0; abort = 0; ack = 0; evals_done = 0;
      req_valid = '0; req_var_idx = '0; req_val = '0; det_conflict = 0;
   endtask

   task automatic model_reset();
      m_active = 0; m_finished = 0; m_conf = 0;
      m_ptr = 0; m_count = 0; m_cvar = 0;
   endtask

   // Compare all outputs against the model at the falling edge, then advance
   // the model to what the next rising edge must produce.
   task automatic cyc_check();
      int g;
      bit idle;
      logic [N-1:0] e_ready;
      @(negedge clk);
      g = -1;
      if (m_active && !abort)
         for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("det_en", 32'(det_en), 32'(g >= 0));
      if (g >= 0) begin
         check("det_var_idx", 32'(det_var_idx), 32'(lane_var(g)));
         check("det_val", 32'(det_val), 32'(req_val[g]));
      end
      check("bcp_done", 32'(bcp_done), 32'(m_finished));
      check("busy", 32'(busy), 32'(m_active || m_finished));
      check("bcp_conflict", 32'(bcp_conflict), 32'(m_conf));
      check("conflict_var_idx", 32'(conflict_var_idx), 32'(m_cvar));
      check("imply_count", 32'(imply_count), 32'(m_count));

      idle = !m_active && !m_finished;
      if (abort) begin
         m_active = 0; m_finished = 0; m_conf = 0;
      end else if (idle) begin
         if (start) begin m_active = 1; m_count = 0; m_conf = 0; end
      end else if (m_active) begin
         if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (det_conflict) begin
               m_cvar = lane_var(g); m_conf = 1; m_active = 0; m_finished = 1;
            end else if (m_count < CNT_MAX) begin
               m_count++;
            end
         end else if (evals_done) begin
            m_active = 0; m_finished = 1;
         end
      end else if (ack) begin
         m_finished = 0;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      cyc_check();
      adv();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst_n = 0;
      #3;
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_det_en", 32'(det_en), 0);
      check("rst_done", 32'(bcp_done), 0);
      check("rst_count", 32'(imply_count), 0);
      @(posedge clk); #1;
      rst_n = 1;
      tick();

      // Basic round: lane 2 offers (5,1), then evals_done.
      start = 1; tick(); start = 0;
      req_valid = 4'b0100; set_lane(2, 5, 1);
      cyc_check();
      check("basic_ready", 32'(req_ready), 32'h4);
      check("basic_det_en", 32'(det_en), 1);
      check("basic_det_var", 32'(det_var_idx), 5);
      adv();
      req_valid = '0; evals_done = 1; tick(); evals_done = 0;
      cyc_check();
      check("basic_done", 32'(bcp_done), 1);
      check("basic_conflict", 32'(bcp_conflict), 0);
      check("basic_count", 32'(imply_count), 1);
      adv();
      ack = 1; tick(); ack = 0;

      // evals_done while lane 3 is valid: lane 3 granted first.
      start = 1; tick(); start = 0;
      req_valid = 4'b1000; set_lane(3, 77, 1); evals_done = 1;
      cyc_check();
      check("ev3_ready", 32'(req_ready), 32'h8);
      check("ev3_not_done", 32'(bcp_done), 0);
      adv();
      req_valid = '0;
      cyc_check();
      check("ev3_still_run", 32'(bcp_done), 0);
      adv();
      cyc_check();
      check("ev3_done", 32'(bcp_done), 1);
      check("ev3_count", 32'(imply_count), 1);
      adv();
      evals_done = 0; ack = 1; tick(); ack = 0;

      // Round-robin fairness, pointer now back at lane 0.
      start = 1; tick(); start = 0;
      for (int i = 0; i < N; i++) set_lane(i, 10 + i, i[0]);
      req_valid = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         cyc_check();
         check("rr_order", 32'(req_ready), 32'(1 << (c % 4)));
         adv();
      end
      req_valid = '0; evals_done = 1; tick(); evals_done = 0;
      cyc_check();
      check("rr_count", 32'(imply_count), 8);
      adv();
      ack = 1; tick(); ack = 0;

      // Conflict on lane 1 (300,0).
      start = 1; tick(); start = 0;
      req_valid = 4'b0010; set_lane(1, 300, 0); det_conflict = 1;
      cyc_check();
      check("cf_ready", 32'(req_ready), 32'h2);
      adv();
      det_conflict = 0; req_valid = 4'b1111;
      cyc_check();
      check("cf_done", 32'(bcp_done), 1);
      check("cf_flag", 32'(bcp_conflict), 1);
      check("cf_var", 32'(conflict_var_idx), 300);
      check("cf_no_ready", 32'(req_ready), 0);
      adv();
      tick(); tick();
      ack = 1; tick(); ack = 0;
      req_valid = '0;
      start = 1; tick(); start = 0;
      cyc_check();
      check("cf_restart_busy", 32'(busy), 1);
      check("cf_restart_clear", 32'(bcp_conflict), 0);
      adv();

      // Conflict and evals_done together: conflict wins.
      req_valid = 4'b0001; set_lane(0, 42, 1); det_conflict = 1; evals_done = 1;
      tick();
      req_valid = '0; det_conflict = 0; evals_done = 0;
      cyc_check();
      check("cfev_flag", 32'(bcp_conflict), 1);
      check("cfev_var", 32'(conflict_var_idx), 42);
      adv();
      ack = 1; tick(); ack = 0;

      // Abort mid-RUN with lanes valid.
      start = 1; tick(); start = 0;
      req_valid = 4'b1111; abort = 1;
      cyc_check();
      check("abort_no_ready", 32'(req_ready), 0);
      adv();
      abort = 0;
      cyc_check();
      check("abort_idle", 32'(busy), 0);
      adv();
      req_valid = '0;
      start = 1; tick(); start = 0;

      // Counter saturation.
      req_valid = 4'b1111;
      for (int c = 0; c < CNT_MAX + 8; c++) tick();
      cyc_check();
      check("sat_count", 32'(imply_count), CNT_MAX);
      adv();
      req_valid = '0; abort = 1; tick(); abort = 0;

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         start        = ($urandom_range(7) == 0);
         abort        = ($urandom_range(31) == 0);
         ack          = ($urandom_range(3) == 0);
         evals_done   = ($urandom_range(7) == 0);
         req_valid    = N'($urandom);
         det_conflict = ($urandom_range(11) == 0);
         for (int i = 0; i < N; i++) set_lane(i, int'($urandom_range(511)), bit'($urandom_range(1)));
         tick();
      end
      clear_inputs();
      abort = 1; tick(); abort = 0;

      // Async reset mid-RUN, between clock edges.
      start = 1; tick(); start = 0;
      req_valid = 4'b0010; set_lane(1, 9, 1); tick();
      req_valid = 4'b1111;
      #1 rst_n = 0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_ready", 32'(req_ready), 0);
      check("arst_det_en", 32'(det_en), 0);
      check("arst_count", 32'(imply_count), 0);
      model_reset();
      #1 rst_n = 1;
      clear_inputs();
      tick();
      start = 1; tick(); start = 0;
      req_valid = 4'b1111;
      cyc_check();
      check("arst_ptr0", 32'(req_ready), 32'h1);
      adv();
      clear_inputs();
      abort = 1; tick(); abort = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/implication_arbiter.md
Name: implication_arbiter

Overview:
Sequences one boolean-constraint-propagation (BCP) round between the clause evaluators and the conflict detector. Multiple clause evaluators offer implications (variable index, value) through valid/ready handshakes. The block grants one implication per cycle in round-robin order and drives the granted implication into the conflict detector. It reports round completion, conflict status, the conflicting variable and the implication count back to the solver FSM.

Parameters:
N_EVAL, 4, number of clause-evaluator requesters (legal range 1..16)
VAR_W, 9, variable index width (512 variables)
CNT_W, 10, implication counter width

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
start  input  1  solver pulse: begin a BCP round
abort  input  1  solver pulse: cancel the round, return to IDLE
ack  input  1  solver acknowledges the round result
evals_done  input  1  all evaluators have finished issuing for this round
req_valid  input  N_EVAL  per-evaluator implication valid
req_var_idx  input  N_EVAL*VAR_W  per-evaluator implied variable, packed, lane i at [i*VAR_W +: VAR_W]
req_val  input  N_EVAL  per-evaluator implied value
req_ready  output  N_EVAL  one-hot grant/accept
det_en  output  1  implication presented to the detector this cycle
det_var_idx  output  VAR_W  variable to detector
det_val  output  1  value to detector
det_conflict  input  1  detector's combinational conflict flag for the presented implication
bcp_done  output  1  round finished; held in DONE
bcp_conflict  output  1  round ended in conflict; valid while bcp_done
conflict_var_idx  output  VAR_W  variable that caused the conflict
imply_count  output  CNT_W  accepted non-conflicting implications this round
busy  output  1  state is not IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; rr_ptr=0; imply_count=0; conflict_var_idx=0; bcp_conflict=0. Combinational outputs evaluate to 0 in IDLE: req_ready=0, det_en=0, bcp_done=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE: all handshakes are inert. When start=1 the next state is RUN; imply_count and bcp_conflict clear to 0. rr_ptr is preserved.
- RUN, grant rule: the grant g is the first lane with req_valid=1, searching from rr_ptr upward with wrap-around.
- RUN, grant outputs (same cycle, combinational): req_ready=onehot(g), det_en=1, det_var_idx=req_var_idx[g], det_val=req_val[g].
- A transfer completes on req_valid[g]&req_ready[g], with zero-cycle latency into the detector.
- On a transfer, rr_ptr <= (g+1) mod N_EVAL.
- On a transfer with det_conflict=0: imply_count++ (saturating at all-ones).
- On a transfer with det_conflict=1: conflict_var_idx <= det_var_idx; bcp_conflict <= 1; next state DONE. The implication is still consumed; imply_count is not incremented.
- RUN with no req_valid: det_en=0 and req_ready=0. If evals_done=1, next state is DONE with bcp_conflict=0.
- evals_done with a valid request pending: the request is granted first; DONE is entered only on a later cycle with no valid request.
- Conflict and evals_done in the same cycle: conflict wins (bcp_conflict=1).
- DONE: bcp_done=1 and req_ready=0. Outputs hold until ack=1, which moves the state to IDLE; bcp_conflict, conflict_var_idx and imply_count stay valid until the next start.
- abort=1 in any state: next state is IDLE, no grant is issued that cycle, and bcp_conflict clears. abort has priority over start, ack and any grant.
- start outside IDLE is ignored.
- det_en is asserted only in RUN.
- With N_EVAL=1, rr_ptr stays 0.

Decomposition:
- Package sat_pkg holds: MAX_VAR_COUNT=512, VAR_W, the implication_t packed struct {var_idx, val}, and the bcp_state_t enum {IDLE, RUN, DONE}. It is shared with the conflict detector and the imply stack.
- One sub-module, rr_arbiter: parameter N; inputs req[N] and ptr; outputs grant one-hot, grant_idx and any_grant.
- Output muxing, the FSM and the counters live in the top level.

Test Plan:
- Basic round: start; lane 2 offers (idx=5, val=1); det_conflict=0; then evals_done -> one cycle with req_ready=4'b0100 and det_en=1; bcp_done=1, bcp_conflict=0, imply_count=1.
- Round-robin fairness: all 4 lanes hold valid for 8 cycles with rr_ptr=0 -> grants go 0,1,2,3,0,1,2,3; imply_count=8.
- Conflict: lane 1 offers idx=300, val=0 and the bench drives det_conflict=1 -> DONE next cycle; bcp_conflict=1, conflict_var_idx=300; no further req_ready until ack, then start.
- Conflict with evals_done in the same cycle -> bcp_conflict=1. evals_done while lane 3 is valid -> lane 3 is granted first, bcp_done asserts a cycle later.
- abort mid-RUN with lanes valid -> no req_ready that cycle; IDLE next cycle; busy=0; subsequent start works normally.
- Async reset asserted mid-RUN (reset=0 between clock edges) -> outputs are immediately 0 and state is IDLE; after release, imply_count=0 and rr_ptr=0.
